// File: rtl/temp_cal_ctrl_pkg.sv
// Shared types and constants for the temperature calibration controller.
// Holds the FSM state encoding, EEPROM word addresses and timeout length.
package temp_cal_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WRT  = 3'd1,
        A2D  = 3'd2,
        ADD  = 3'd3,
        MUL  = 3'd4
    } state_t;

    localparam logic        ADDR_OFFSET = 1'b0;
    localparam logic        ADDR_GAIN   = 1'b1;
    localparam logic [11:0] UNITY_GAIN  = 12'h800;
    localparam int          A2D_TIMEOUT = 256;
    localparam int          TIMER_W     = 8;

endpackage

// File: rtl/temp_cal_ctrl_a2d_timer.sv
// Converter watchdog: 8-bit up-counter with synchronous clear and count enable.
// tc is high in the last cycle of the timeout window.
module a2d_timer
    import temp_cal_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Count starts at 0 in the first waiting cycle, so cycle N of the window sees N-1.
    assign tc = (count == TIMER_W'(A2D_TIMEOUT - 1));

endmodule

// File: rtl/temp_cal_ctrl.sv
// Sequencer for a calibrated temperature conversion: A2D sample, add offset,
// multiply by gain, with EEPROM calibration-word writes and a converter timeout.
// Handshake: strt_cnv/wrt_cal are accepted only in IDLE (busy=0) and are
// dropped otherwise; rdy marks temp valid until the next accepted strt_cnv.
module temp_cal_ctrl
    import temp_cal_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic        wrt_cal,
    input  logic        cal_sel,
    input  logic [11:0] cal_data,
    input  logic        a2d_rdy,
    input  logic [11:0] res,
    output logic        strt_a2d,
    output logic        addr,
    output logic        mult,
    output logic        WE,
    output logic        wrtTmp,
    output logic [11:0] wdata,
    output logic [11:0] temp,
    output logic        rdy,
    output logic        busy,
    output logic        err,
    output logic [2:0]  state_dbg
);

    state_t state;
    state_t state_next;

    logic cal_sel_q;
    logic accept_cnv;
    logic accept_wrt;
    logic timer_en;
    logic timer_tc;
    logic timeout;
    logic finish;

    a2d_timer u_a2d_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_cnv),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        addr       = ADDR_OFFSET;
        mult       = 1'b0;
        WE         = 1'b0;
        wrtTmp     = 1'b0;
        accept_cnv = 1'b0;
        accept_wrt = 1'b0;
        timer_en   = 1'b0;
        timeout    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                // A calibration write wins over a conversion request in the same cycle.
                if (wrt_cal) begin
                    accept_wrt = 1'b1;
                    state_next = WRT;
                end else if (strt_cnv) begin
                    accept_cnv = 1'b1;
                    state_next = A2D;
                end
            end
            WRT: begin
                WE         = 1'b1;
                addr       = cal_sel_q;
                state_next = IDLE;
            end
            A2D: begin
                timer_en = 1'b1;
                if (a2d_rdy) begin
                    state_next = ADD;
                end else if (timer_tc) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            ADD: begin
                addr       = ADDR_OFFSET;
                wrtTmp     = 1'b1;
                state_next = MUL;
            end
            MUL: begin
                addr       = ADDR_GAIN;
                mult       = 1'b1;
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_sel_q <= ADDR_OFFSET;
            wdata     <= '0;
        end else if (accept_wrt) begin
            cal_sel_q <= cal_sel;
            wdata     <= cal_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strt_a2d <= 1'b0;
            temp     <= '0;
            rdy      <= 1'b0;
            err      <= 1'b0;
        end else begin
            strt_a2d <= accept_cnv;
            if (accept_cnv) begin
                rdy <= 1'b0;
                err <= 1'b0;
            end else begin
                if (finish) begin
                    rdy <= 1'b1;
                end
                if (timeout) begin
                    err <= 1'b1;
                end
            end
            if (finish) begin
                temp <= res;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_temp_cal_ctrl.sv
// Bench for temp_cal_ctrl with a behavioural datapath (signed offset add, Q1.11
// gain multiply, both saturating) and a simple A2D model.
module tb_temp_cal_ctrl;
    import temp_cal_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        strt_cnv;
    logic        wrt_cal;
    logic        cal_sel;
    logic [11:0] cal_data;
    logic        a2d_rdy;
    logic [11:0] res;
    logic        strt_a2d;
    logic        addr;
    logic        mult;
    logic        WE;
    logic        wrtTmp;
    logic [11:0] wdata;
    logic [11:0] temp;
    logic        rdy;
    logic        busy;
    logic        err;
    logic [2:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    // {timeout_expected, temp_expected}
    logic [12:0] exp_q[$];
    // {addr, wdata}
    logic [12:0] we_q[$];

    logic [11:0] a2d_val;
    logic        a2d_on;
    logic [11:0] eep [2];
    logic [11:0] dp_tmp;
    int          tmp_writes = 0;
    int          cyc = 0;
    int          rdy_seen_cyc = -100;
    int          busy_start = 0;
    logic        rdy_q = 1'b0;
    logic        err_q = 1'b0;
    logic        busy_q = 1'b0;

    temp_cal_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .wrt_cal   (wrt_cal),
        .cal_sel   (cal_sel),
        .cal_data  (cal_data),
        .a2d_rdy   (a2d_rdy),
        .res       (res),
        .strt_a2d  (strt_a2d),
        .addr      (addr),
        .mult      (mult),
        .WE        (WE),
        .wrtTmp    (wrtTmp),
        .wdata     (wdata),
        .temp      (temp),
        .rdy       (rdy),
        .busy      (busy),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural datapath ----------------
    function automatic logic [11:0] dp_res(input logic m, input logic [11:0] a,
                                           input logic [11:0] t, input logic [11:0] w);
        int s;
        if (!m) s = int'({20'd0, a}) + int'($signed(w));
        else    s = (int'({20'd0, t}) * int'({20'd0, w})) >>> 11;
        if (s < 0)    s = 0;
        if (s > 4095) s = 4095;
        return s[11:0];
    endfunction

    assign res = dp_res(mult, a2d_val, dp_tmp, eep[addr]);

    always @(posedge clk) begin
        if (WE) eep[addr] <= wdata;
        if (wrtTmp) begin
            dp_tmp     <= res;
            tmp_writes <= tmp_writes + 1;
        end
        if (a2d_rdy) rdy_seen_cyc <= cyc;
    end

    // ---------------- A2D model ----------------
    initial begin
        a2d_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (strt_a2d && a2d_on) begin
                repeat (3) @(posedge clk);
                #1 a2d_rdy = 1'b1;
                @(posedge clk);
                #1 a2d_rdy = 1'b0;
            end
        end
    end

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [12:0] e;
        if (rst_n) begin
            if (rdy && !rdy_q) begin
                chk("conv_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("conv_kind", {31'd0, e[12]}, 0);
                    chk("temp", temp, e[11:0]);
                    chk("rdy_latency", cyc - 1 - rdy_seen_cyc, 2);
                end
            end
            if (err && !err_q) begin
                chk("timeout_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("timeout_kind", {31'd0, e[12]}, 1);
                    chk("timeout_temp", temp, e[11:0]);
                    chk("timeout_busy", busy, 0);
                    chk("timeout_rdy", rdy, 0);
                    chk("timeout_cycles", cyc - busy_start, A2D_TIMEOUT);
                end
            end
            if (WE) begin
                chk("we_pending", we_q.size() > 0, 1);
                if (we_q.size() > 0) begin
                    e = we_q.pop_front();
                    chk("we_addr", addr, e[12]);
                    chk("we_data", wdata, e[11:0]);
                    chk("we_mult", mult, 0);
                end
            end
            if (busy && !busy_q) busy_start = cyc;
        end
        rdy_q  = rdy;
        err_q  = err;
        busy_q = busy;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_idle"}, busy, 0);
    endtask

    task automatic pulse_cnv();
        strt_cnv = 1'b1;
        @(posedge clk);
        #1 strt_cnv = 1'b0;
    endtask

    task automatic write_cal(input logic sel, input logic [11:0] data);
        we_q.push_back({sel, data});
        wrt_cal  = 1'b1;
        cal_sel  = sel;
        cal_data = data;
        @(posedge clk);
        #1 wrt_cal = 1'b0;
        wait_idle("write");
    endtask

    task automatic convert(input logic [11:0] a, input logic [11:0] exp);
        a2d_val = a;
        a2d_on  = 1'b1;
        exp_q.push_back({1'b0, exp});
        pulse_cnv();
        wait_idle("conv");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int tw;
        rst_n    = 1'b0;
        strt_cnv = 1'b0;
        wrt_cal  = 1'b0;
        cal_sel  = 1'b0;
        cal_data = 12'h000;
        a2d_val  = 12'h000;
        a2d_on   = 1'b1;

        #23;
        chk("rst_temp", temp, 12'h000);
        chk("rst_rdy", rdy, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strt_a2d", strt_a2d, 0);
        chk("rst_we", WE, 0);
        chk("rst_wrttmp", wrtTmp, 0);
        chk("rst_addr", addr, 0);
        chk("rst_mult", mult, 0);
        chk("rst_wdata", wdata, 12'h000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Offset -2, unity gain
        write_cal(1'b0, 12'hFFE);
        write_cal(1'b1, 12'h800);
        convert(12'h003, 12'h001);
        chk("wdata_hold", wdata, 12'h800);
        chk("rdy_held", rdy, 1);

        // Gain 1.5
        write_cal(1'b1, 12'hC00);
        write_cal(1'b0, 12'h000);
        convert(12'h89A, 12'hCE7);

        // Saturation after add and after multiply
        write_cal(1'b0, 12'h555);
        write_cal(1'b1, 12'h800);
        convert(12'hABC, 12'hFFF);
        write_cal(1'b1, 12'hC00);
        write_cal(1'b0, 12'h000);
        convert(12'hABC, 12'hFFF);

        // Converter timeout, then recovery
        a2d_on = 1'b0;
        exp_q.push_back({1'b1, 12'hFFF});
        pulse_cnv();
        wait_idle("timeout");
        chk("timeout_err", err, 1);
        chk("timeout_temp_kept", temp, 12'hFFF);
        a2d_on  = 1'b1;
        a2d_val = 12'h100;
        exp_q.push_back({1'b0, 12'h180});
        pulse_cnv();
        chk("err_cleared", err, 0);
        chk("strt_a2d_pulse", strt_a2d, 1);
        @(posedge clk);
        #1;
        chk("strt_a2d_one_cycle", strt_a2d, 0);
        wait_idle("recover");

        // Write and convert in the same IDLE cycle: write wins, conversion dropped
        we_q.push_back({1'b0, 12'h010});
        wrt_cal  = 1'b1;
        cal_sel  = 1'b0;
        cal_data = 12'h010;
        strt_cnv = 1'b1;
        @(posedge clk);
        #1;
        wrt_cal  = 1'b0;
        strt_cnv = 1'b0;
        chk("priority_state", state_dbg, 32'(WRT));
        chk("priority_no_a2d", strt_a2d, 0);
        wait_idle("priority");
        repeat (5) @(posedge clk);
        #1;
        chk("dropped_conv_busy", busy, 0);
        chk("dropped_conv_rdy", rdy, 1);

        // Requests during MUL are ignored
        a2d_val = 12'h100;
        exp_q.push_back({1'b0, 12'h198});
        pulse_cnv();
        n = 0;
        while (!mult && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached_mul", mult, 1);
        strt_cnv = 1'b1;
        wrt_cal  = 1'b1;
        cal_sel  = 1'b1;
        cal_data = 12'h123;
        @(posedge clk);
        #1;
        strt_cnv = 1'b0;
        wrt_cal  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mul_req_ignored_busy", busy, 0);
        chk("mul_req_ignored_wdata", wdata, 12'h010);

        // Asynchronous reset during ADD
        a2d_val = 12'h300;
        pulse_cnv();
        n = 0;
        while (!wrtTmp && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached_add", wrtTmp, 1);
        #2 rst_n = 1'b0;
        #1;
        tw = tmp_writes;
        chk("arst_busy", busy, 0);
        chk("arst_wrttmp", wrtTmp, 0);
        chk("arst_we", WE, 0);
        chk("arst_addr", addr, 0);
        chk("arst_mult", mult, 0);
        chk("arst_rdy", rdy, 0);
        chk("arst_err", err, 0);
        chk("arst_temp", temp, 12'h000);
        chk("arst_wdata", wdata, 12'h000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("arst_no_tmp_write", tmp_writes, tw);
        chk("arst_tmp_kept", dp_tmp, 12'h110);
        chk("arst_idle", busy, 0);

        // Normal operation after reset (EEPROM keeps offset 0x010, gain 0xC00)
        convert(12'h200, 12'h318);

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("we_q_drained", we_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
